// File: rtl/sincos_table_ctrl.sv
// Write-port arbiter and validity tracker for the sine/cosine SRAM pair.
// Host word writes and a zero-fill sweep share port 0; port 1 is gated on a committed table.
module sincos_table_ctrl #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 512,
  parameter bit          LIVE_WR = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [3:0]        host_wmask,
  input  logic [DATA_W-1:0] host_sin,
  input  logic [DATA_W-1:0] host_cos,
  input  logic              host_commit,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              run_en,
  output logic              table_ready,
  output logic              csb0,
  output logic              web0,
  output logic [3:0]        wmask0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din00,
  output logic [DATA_W-1:0] din01,
  output logic              csb1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HWR  = 2'd1,
    ST_CLR  = 2'd2
  } state_t;

  // The sweep counter is one bit wider than the address so DEPTH == 2**ADDR_W still terminates.
  localparam int unsigned     LAST_INT = DEPTH - 1;
  localparam logic [ADDR_W:0] LAST_IDX = LAST_INT[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic [ADDR_W:0]     cnt_r, cnt_s, cnt_inc_s;
  logic                csb0_r, csb0_s;
  logic                web0_r, web0_s;
  logic [3:0]          wmask0_r, wmask0_s;
  logic [ADDR_W-1:0]   addr0_r, addr0_s;
  logic [DATA_W-1:0]   din00_r, din00_s;
  logic [DATA_W-1:0]   din01_r, din01_s;
  logic                csb1_r, csb1_s;
  logic                table_ready_r, table_ready_s;
  logic                clr_done_r, clr_done_s;
  logic                live_block_s;
  logic                accept_s;

  assign cnt_inc_s    = cnt_r + CNT_ONE;
  assign live_block_s = (LIVE_WR == 1'b0) && run_en && table_ready_r;
  assign host_ready   = reset && (state_r != ST_CLR) && !clr_start && !live_block_s;
  assign accept_s     = host_valid && host_ready;

  // Next-state and next-port-value logic; a pending clear outranks host writes and commits.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    csb0_s        = csb0_r;
    web0_s        = web0_r;
    wmask0_s      = wmask0_r;
    addr0_s       = addr0_r;
    din00_s       = din00_r;
    din01_s       = din01_r;
    table_ready_s = table_ready_r;
    clr_done_s    = 1'b0;
    csb1_s        = ~(run_en & table_ready_r);
    case (state_r)
      ST_IDLE, ST_HWR: begin
        if (clr_start) begin
          state_s       = ST_CLR;
          cnt_s         = {(ADDR_W+1){1'b0}};
          csb0_s        = 1'b0;
          web0_s        = 1'b0;
          wmask0_s      = 4'hF;
          addr0_s       = {ADDR_W{1'b0}};
          din00_s       = {DATA_W{1'b0}};
          din01_s       = {DATA_W{1'b0}};
          table_ready_s = 1'b0;
        end else begin
          if (accept_s) begin
            state_s  = ST_HWR;
            csb0_s   = 1'b0;
            web0_s   = 1'b0;
            wmask0_s = host_wmask;
            addr0_s  = host_addr;
            din00_s  = host_sin;
            din01_s  = host_cos;
          end else begin
            state_s = ST_IDLE;
            csb0_s  = 1'b1;
            web0_s  = 1'b1;
          end
          if (host_commit) begin
            table_ready_s = 1'b1;
          end else begin
            table_ready_s = table_ready_r;
          end
        end
      end
      ST_CLR: begin
        if (cnt_r == LAST_IDX) begin
          state_s    = ST_IDLE;
          csb0_s     = 1'b1;
          web0_s     = 1'b1;
          clr_done_s = 1'b1;
        end else begin
          cnt_s   = cnt_inc_s;
          addr0_s = cnt_inc_s[ADDR_W-1:0];
        end
      end
      default: begin
        state_s = ST_IDLE;
        csb0_s  = 1'b1;
        web0_s  = 1'b1;
      end
    endcase
  end

  // State and registered SRAM-port outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {(ADDR_W+1){1'b0}};
      csb0_r        <= 1'b1;
      web0_r        <= 1'b1;
      wmask0_r      <= 4'h0;
      addr0_r       <= {ADDR_W{1'b0}};
      din00_r       <= {DATA_W{1'b0}};
      din01_r       <= {DATA_W{1'b0}};
      csb1_r        <= 1'b1;
      table_ready_r <= 1'b0;
      clr_done_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      csb0_r        <= csb0_s;
      web0_r        <= web0_s;
      wmask0_r      <= wmask0_s;
      addr0_r       <= addr0_s;
      din00_r       <= din00_s;
      din01_r       <= din01_s;
      csb1_r        <= csb1_s;
      table_ready_r <= table_ready_s;
      clr_done_r    <= clr_done_s;
    end
  end

  assign clr_busy    = (state_r == ST_CLR);
  assign clr_done    = clr_done_r;
  assign table_ready = table_ready_r;
  assign csb0        = csb0_r;
  assign web0        = web0_r;
  assign wmask0      = wmask0_r;
  assign addr0       = addr0_r;
  assign din00       = din00_r;
  assign din01       = din01_r;
  assign csb1        = csb1_r;

endmodule

// File: tb/tb_sincos_table_ctrl.sv
// Directed bench for sincos_table_ctrl: host writes, commit/read gating, live-write stall,
// full clear sweep, clear/commit/write collision and reset mid-clear.
module tb_sincos_table_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [3:0]        host_wmask;
  logic [DATA_W-1:0] host_sin;
  logic [DATA_W-1:0] host_cos;
  logic              host_commit;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic              run_en;
  logic              table_ready;
  logic              csb0;
  logic              web0;
  logic [3:0]        wmask0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] din00;
  logic [DATA_W-1:0] din01;
  logic              csb1;

  int checks = 0;
  int errors = 0;

  sincos_table_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LIVE_WR(1'b0)) dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
    .host_wmask(host_wmask), .host_sin(host_sin), .host_cos(host_cos),
    .host_commit(host_commit), .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done), .run_en(run_en), .table_ready(table_ready),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din00(din00), .din01(din01), .csb1(csb1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_port(input string tag);
    chk({tag, ".csb0"}, 64'(csb0), 64'd1);
    chk({tag, ".web0"}, 64'(web0), 64'd1);
  endtask

  task automatic host_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] s,
                           input logic [DATA_W-1:0] c);
    host_valid = 1'b1;
    host_addr  = a;
    host_sin   = s;
    host_cos   = c;
    host_wmask = 4'hF;
    tick();
    chk("hw.csb0", 64'(csb0), 64'd0);
    chk("hw.web0", 64'(web0), 64'd0);
    chk("hw.addr0", 64'(addr0), 64'(a));
    chk("hw.din00", 64'(din00), 64'(s));
    chk("hw.din01", 64'(din01), 64'(c));
    chk("hw.wmask0", 64'(wmask0), 64'hF);
  endtask

  initial begin
    reset = 1'b0; host_valid = 1'b0; host_addr = '0; host_wmask = 4'h0;
    host_sin = '0; host_cos = '0; host_commit = 1'b0; clr_start = 1'b0; run_en = 1'b0;

    // Reset values
    tick();
    tick();
    chk_idle_port("rst");
    chk("rst.csb1", 64'(csb1), 64'd1);
    chk("rst.table_ready", 64'(table_ready), 64'd0);
    chk("rst.host_ready", 64'(host_ready), 64'd0);
    chk("rst.clr_busy", 64'(clr_busy), 64'd0);
    chk("rst.clr_done", 64'(clr_done), 64'd0);
    chk("rst.wmask0", 64'(wmask0), 64'd0);
    chk("rst.addr0", 64'(addr0), 64'd0);
    chk("rst.din00", 64'(din00), 64'd0);
    reset = 1'b1;
    #1;
    chk("rel.host_ready", 64'(host_ready), 64'd1);
    tick();
    chk_idle_port("idle");

    // Three back-to-back host writes, then return to idle with data held
    host_word(9'd5, 32'h11, 32'hA1);
    host_word(9'd6, 32'h22, 32'hA2);
    host_word(9'd7, 32'h33, 32'hA3);
    host_valid = 1'b0;
    tick();
    chk_idle_port("hw_end");
    chk("hw_end.addr0_hold", 64'(addr0), 64'd7);
    chk("hw_end.din00_hold", 64'(din00), 64'h33);

    // Commit then run: table_ready after one edge, csb1 low one edge later
    host_commit = 1'b1;
    tick();
    host_commit = 1'b0;
    chk("commit.table_ready", 64'(table_ready), 64'd1);
    chk("commit.csb1", 64'(csb1), 64'd1);
    run_en = 1'b1;
    tick();
    chk("run.csb1", 64'(csb1), 64'd0);

    // Live table with LIVE_WR=0 stalls host writes
    host_valid = 1'b1;
    host_addr  = 9'd9;
    host_sin   = 32'hDEAD;
    #1;
    chk("stall.host_ready", 64'(host_ready), 64'd0);
    tick();
    chk_idle_port("stall");
    chk("stall.addr0", 64'(addr0), 64'd7);
    host_valid = 1'b0;

    // Full clear sweep
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("clr0.clr_busy", 64'(clr_busy), 64'd1);
    chk("clr0.table_ready", 64'(table_ready), 64'd0);
    chk("clr0.csb1", 64'(csb1), 64'd0);
    chk("clr0.addr0", 64'(addr0), 64'd0);
    chk("clr0.csb0", 64'(csb0), 64'd0);
    chk("clr0.web0", 64'(web0), 64'd0);
    chk("clr0.wmask0", 64'(wmask0), 64'hF);
    chk("clr0.din00", 64'(din00), 64'd0);
    chk("clr0.din01", 64'(din01), 64'd0);
    for (int i = 1; i < DEPTH; i++) begin
      clr_start = (i == 200);
      tick();
      chk("clr.addr0", 64'(addr0), 64'(i));
      chk("clr.busy", 64'(clr_busy), 64'd1);
      chk("clr.csb0", 64'(csb0), 64'd0);
      chk("clr.din00", 64'(din00), 64'd0);
      chk("clr.csb1", 64'(csb1), 64'd1);
      chk("clr.done", 64'(clr_done), 64'd0);
      if (i == 300) begin
        chk("clr.host_ready", 64'(host_ready), 64'd0);
        chk("clr.table_ready", 64'(table_ready), 64'd0);
        chk("clr.wmask0", 64'(wmask0), 64'hF);
      end
    end
    clr_start = 1'b0;
    tick();
    chk("clr_end.busy", 64'(clr_busy), 64'd0);
    chk("clr_end.done", 64'(clr_done), 64'd1);
    chk_idle_port("clr_end");
    tick();
    chk("clr_end.done_pulse", 64'(clr_done), 64'd0);
    chk("clr_end.table_ready", 64'(table_ready), 64'd0);

    // Clear, commit and host write in the same cycle: clear wins
    run_en      = 1'b0;
    clr_start   = 1'b1;
    host_commit = 1'b1;
    host_valid  = 1'b1;
    host_addr   = 9'd3;
    host_sin    = 32'h55;
    #1;
    chk("coll.host_ready", 64'(host_ready), 64'd0);
    tick();
    clr_start = 1'b0; host_commit = 1'b0; host_valid = 1'b0;
    chk("coll.clr_busy", 64'(clr_busy), 64'd1);
    chk("coll.table_ready", 64'(table_ready), 64'd0);
    chk("coll.addr0", 64'(addr0), 64'd0);
    chk("coll.din00", 64'(din00), 64'd0);

    // Reset at clear address 100 aborts the sweep
    for (int i = 0; i < 100; i++) tick();
    chk("mid.addr0", 64'(addr0), 64'd100);
    reset = 1'b0;
    tick();
    chk_idle_port("abort");
    chk("abort.addr0", 64'(addr0), 64'd0);
    chk("abort.wmask0", 64'(wmask0), 64'd0);
    chk("abort.din01", 64'(din01), 64'd0);
    chk("abort.clr_busy", 64'(clr_busy), 64'd0);
    chk("abort.clr_done", 64'(clr_done), 64'd0);
    chk("abort.csb1", 64'(csb1), 64'd1);
    chk("abort.table_ready", 64'(table_ready), 64'd0);
    chk("abort.host_ready", 64'(host_ready), 64'd0);
    reset = 1'b1;
    tick();
    chk("post.clr_busy", 64'(clr_busy), 64'd0);
    chk("post.addr0", 64'(addr0), 64'd0);
    chk_idle_port("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
